// File: rtl/perf_event_counters_pkg.sv
// Shared types and constants for the performance event counter bank.
// Imported by the counter bank top and its counter cell.
package perf_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } perf_state_e;

    localparam int EVT_RETIRE = 0;
    localparam int EVT_IREQ   = 1;
    localparam int EVT_IHIT   = 2;
    localparam int EVT_DREQ   = 3;
    localparam int EVT_DHIT   = 4;

    localparam int DRAIN_W = 8;

endpackage

// File: rtl/perf_event_counters_if.sv
// Event/control/read bundle between the pipeline and the counter bank.
// PERF_SNAPSHOT_EN adds the snap and rd_shadow controls.
interface perf_event_counters_if #(
    parameter int NUM_EVENTS = 5,
    parameter int CNT_WIDTH  = 32
);
    localparam int SEL_W = $clog2(NUM_EVENTS + 1);

    logic [NUM_EVENTS-1:0] evt;
    logic                  halt;
    logic                  clr;
    logic [SEL_W-1:0]      rd_sel;
    logic [CNT_WIDTH-1:0]  rd_data;
    logic [NUM_EVENTS:0]   ovf;
    logic [1:0]            state_o;
    logic                  done;
`ifdef PERF_SNAPSHOT_EN
    logic                  snap;
    logic                  rd_shadow;

    modport master (
        output evt, halt, clr, rd_sel, snap, rd_shadow,
        input  rd_data, ovf, state_o, done
    );
    modport slave (
        input  evt, halt, clr, rd_sel, snap, rd_shadow,
        output rd_data, ovf, state_o, done
    );
`else
    modport master (
        output evt, halt, clr, rd_sel,
        input  rd_data, ovf, state_o, done
    );
    modport slave (
        input  evt, halt, clr, rd_sel,
        output rd_data, ovf, state_o, done
    );
`endif
endinterface

// File: rtl/perf_counter_cell.sv
// One event counter: +1 per inc, wrap or saturate, sticky overflow.
// clr beats inc; freeze holds the count and overflow flag.
module perf_counter_cell #(
    parameter int CNT_WIDTH = 32,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    input  logic                 freeze,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 at_max;

    assign at_max = &cnt_q;

    // Next count: clear first, then an unfrozen increment that wraps or sticks
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc && !freeze) begin
            if (at_max) begin
                ovf_d = 1'b1;
                cnt_d = (SATURATE != 0) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Count and overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/perf_event_counters.sv
// Bank of event counters plus a cycle counter with halt drain and freeze.
// Define PERF_SNAPSHOT_EN for the snap/rd_shadow shadow bank.
module perf_event_counters
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS   = 5,
    parameter int CNT_WIDTH    = 32,
    parameter int SATURATE     = 0,
    parameter int DRAIN_CYCLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    perf_event_counters_if.slave bus
);
    localparam int NCNT  = NUM_EVENTS + 1;
    localparam int SEL_W = $clog2(NCNT);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;

    perf_state_e          state_q, state_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [CNT_WIDTH-1:0] cnt [NCNT];
    logic [NCNT-1:0]      ovf;
    logic [NCNT-1:0]      inc;
    logic                 freeze;

    // Cycle counter always ticks; everything holds once DONE
    assign inc    = {1'b1, bus.evt};
    assign freeze = (state_q == DONE);

    for (genvar g = 0; g < NCNT; g++) begin : g_cell
        perf_counter_cell #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .clr    (bus.clr),
            .inc    (inc[g]),
            .freeze (freeze),
            .cnt    (cnt[g]),
            .ovf    (ovf[g])
        );
    end

    // Run/drain/done sequencing; clr rearms from any state
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (bus.clr) begin
            state_d = RUN;
            drain_d = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.halt) begin
                        if (DRAIN_CYCLES > 0) begin
                            state_d = DRAIN;
                            drain_d = DRAIN_LOAD;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_d = DONE;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
        done_d = (state_d == DONE) && (state_q != DONE);
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] shadow_q [NCNT];
    logic [CNT_WIDTH-1:0] shadow_d [NCNT];
    logic                 snap_fire;

    assign snap_fire = bus.snap | done_q;

    // Shadow bank captures pre-increment counts on snap or done
    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            shadow_d[i] = snap_fire ? cnt[i] : shadow_q[i];
        end
    end

    // Shadow registers survive clr; only rst clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCNT; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end
`endif

    // Read mux; out-of-range selects read as zero
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
`ifdef PERF_SNAPSHOT_EN
                rd_data_d = bus.rd_shadow ? shadow_q[i] : cnt[i];
`else
                rd_data_d = cnt[i];
`endif
            end
        end
    end

    // State, drain, done and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            drain_q   <= '0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.ovf     = ovf;
    assign bus.state_o = state_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_perf_event_counters.sv
// Scoreboard bench: wrap and saturate banks driven in lockstep, checked
// against a cycle-level behavioural model of the counting rules.
module tb_perf_event_counters;

    localparam int N    = 5;
    localparam int W    = 4;
    localparam int NC   = N + 1;
    localparam int DR   = 4;
    localparam int MAXV = (1 << W) - 1;

    typedef struct packed {
        logic [W-1:0] rd;
        logic [N:0]   ovf;
        logic [1:0]   st;
        logic         dn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    perf_event_counters_if #(.NUM_EVENTS(N), .CNT_WIDTH(W)) bw ();
    perf_event_counters_if #(.NUM_EVENTS(N), .CNT_WIDTH(W)) bs ();

    perf_event_counters #(
        .NUM_EVENTS(N), .CNT_WIDTH(W), .SATURATE(0), .DRAIN_CYCLES(DR)
    ) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bw)
    );

    perf_event_counters #(
        .NUM_EVENTS(N), .CNT_WIDTH(W), .SATURATE(1), .DRAIN_CYCLES(DR)
    ) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bs)
    );

    exp_t qw[$];
    exp_t qs[$];
    int   checks = 0;
    int   errors = 0;

    // Model: counts per channel, sticky flags, phase 0 run/1 drain/2 done
    int       mcnt [2][NC];
    bit [N:0] movf [2];
    int       mphase [2];
    int       mleft [2];

    task automatic model_step(input int m, input bit r, input bit c,
                              input bit h, input logic [N-1:0] e,
                              input int sel, output exp_t x);
        bit dn;
        dn = 1'b0;
        if (r) x.rd = '0;
        else if (sel < NC) x.rd = W'(mcnt[m][sel]);
        else x.rd = '0;
        if (r || c) begin
            for (int i = 0; i < NC; i++) mcnt[m][i] = 0;
            movf[m]   = '0;
            mphase[m] = 0;
            mleft[m]  = 0;
        end else if (mphase[m] != 2) begin
            for (int i = 0; i < NC; i++) begin
                if (i == N || e[i]) begin
                    if (mcnt[m][i] == MAXV) begin
                        movf[m][i] = 1'b1;
                        if (m == 0) mcnt[m][i] = 0;
                    end else begin
                        mcnt[m][i] = mcnt[m][i] + 1;
                    end
                end
            end
            if (mphase[m] == 0) begin
                if (h) begin
                    mleft[m]  = DR;
                    mphase[m] = (DR == 0) ? 2 : 1;
                    dn = (mphase[m] == 2);
                end
            end else begin
                mleft[m] = mleft[m] - 1;
                if (mleft[m] == 0) begin
                    mphase[m] = 2;
                    dn = 1'b1;
                end
            end
        end
        x.ovf = movf[m];
        x.st  = 2'(mphase[m]);
        x.dn  = dn;
    endtask

    task automatic step(input bit r, input bit c, input bit h,
                        input logic [N-1:0] e, input int sel);
        exp_t x;
        @(negedge clk);
        rst       = r;
        bw.clr    = c;
        bs.clr    = c;
        bw.halt   = h;
        bs.halt   = h;
        bw.evt    = e;
        bs.evt    = e;
        bw.rd_sel = 3'(sel);
        bs.rd_sel = 3'(sel);
        model_step(0, r, c, h, e, sel, x);
        qw.push_back(x);
        model_step(1, r, c, h, e, sel, x);
        qs.push_back(x);
    endtask

    function automatic void chk(string nm, exp_t e, exp_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s rd got %0d want %0d ovf got %b want %b st got %0d want %0d done got %b want %b",
                     nm, a.rd, e.rd, a.ovf, e.ovf, a.st, e.st, a.dn, e.dn);
        end
    endfunction

    // Monitor: one expected response per clock for each bank
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (qw.size() > 0)
                chk("wrap_bank", qw.pop_front(),
                    {bw.rd_data, bw.ovf, bw.state_o, bw.done});
            if (qs.size() > 0)
                chk("sat_bank", qs.pop_front(),
                    {bs.rd_data, bs.ovf, bs.state_o, bs.done});
        end
    end

    initial begin
        bit r, c, h;
        bw.evt = '0; bs.evt = '0;
        bw.halt = 1'b0; bs.halt = 1'b0;
        bw.clr = 1'b0; bs.clr = 1'b0;
        bw.rd_sel = '0; bs.rd_sel = '0;
`ifdef PERF_SNAPSHOT_EN
        bw.snap = 1'b0; bs.snap = 1'b0;
        bw.rd_shadow = 1'b0; bs.rd_shadow = 1'b0;
`endif
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        step(0, 0, 0, '0, 5);

        // Basic retire count
        repeat (10) step(0, 0, 0, 5'b00001, 0);
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 5);
        step(0, 0, 0, '0, 7);

        // Halt with DCacheReq held through drain and after freeze
        step(1, 0, 0, '0, 0);
        repeat (19) step(0, 0, 0, '0, $urandom_range(0, 7));
        step(0, 0, 1, 5'b01000, 3);
        repeat (14) step(0, 0, 0, 5'b01000, 3);

        // clr beats halt and events in DONE
        step(0, 1, 1, 5'h1f, 3);
        step(0, 0, 0, '0, 0);

        // Wrap vs saturate on channel 2
        repeat (17) step(0, 0, 0, 5'b00100, 2);
        step(0, 0, 0, '0, 2);
        step(0, 0, 0, '0, 2);

        // Reset mid-drain, then a normal drain
        step(0, 1, 0, '0, 0);
        step(0, 0, 1, 5'b00011, 0);
        step(0, 0, 0, 5'b00011, 1);
        step(1, 0, 0, 5'b00011, 0);
        repeat (3) step(0, 0, 0, 5'b00010, 1);
        step(0, 0, 1, 5'b00010, 1);
        repeat (8) step(0, 0, 0, 5'b00010, 1);

        // Randomised traffic
        repeat (3000) begin
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 49) == 0);
            h = ($urandom_range(0, 19) == 0);
            step(r, c, h, 5'($urandom), $urandom_range(0, 7));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (qw.size() != 0 || qs.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left %0d/%0d want 0/0",
                     qw.size(), qs.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
